kernel_loader: RTL and testbench
================================

# kernel_loader

Sequencing controller for a convolution array of `SLICE_NB` slices of `MAC_NB` multiply-add stages each. It accepts a kernel as a stream of `SLICE_NB*MAC_NB` weights and writes each weight into its MAC through a shared weight bus with one-hot write strobes. It gates the image stream so pixels enter the array only when a complete kernel is resident. Before a reload, it drains the array pipeline so in-flight pixels never see a partially updated kernel.

## Interface
- `SLICE_NB`, 3, number of slices driven.
- `MAC_NB`, 3, MAC stages per slice.
- `WEIGHT_WIDTH`, 16, weight bit width.
- `IMAGE_WIDTH`, 16, pixel bit width; the image bus is `IMAGE_WIDTH*MAC_NB`.
- `DRAIN_CYCLES`, 19, array pipeline depth in cycles (slice pipeline 6*3+1); must be ≥1.
- Clocking and reset: one clock, `clk`; reset is `rst`, synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `load_start`  in  1  request to (re)load a kernel; single-cycle pulse.
- `cfg_weight`  in  WEIGHT_WIDTH  incoming kernel weight.
- `cfg_valid`  in  1  `cfg_weight` valid.
- `cfg_ready`  out  1  controller accepts a weight.
- `weight`  out  WEIGHT_WIDTH  shared weight bus to all slices.
- `weight_valid`  out  SLICE_NB*MAC_NB  one-hot write strobe; bit `s*MAC_NB+m` is slice `s`, MAC `m`.
- `image_in`  in  IMAGE_WIDTH*MAC_NB  upstream pixel beat.
- `image_in_valid`  in  1  upstream beat valid.
- `image_in_ready`  out  1  controller accepts a beat.
- `image_out`  out  IMAGE_WIDTH*MAC_NB  registered pixel beat to the array.
- `image_out_valid`  out  1  registered valid to the array.
- `loaded`  out  1  a full kernel is resident and the stream is open.

## Operation
- States: `EMPTY`, `LOAD`, `RUN`, `DRAIN`. Reset enters `EMPTY`.
- Reset values: `cfg_ready`=0, `weight`=0, `weight_valid`=0, `image_in_ready`=0, `image_out`=0, `image_out_valid`=0, `loaded`=0. Weight index and drain counter are cleared.
- `EMPTY`: `load_start` → `LOAD` with index 0. A pending `cfg_valid` is ignored.
- `LOAD`: `cfg_ready`=1. Each `cfg_valid&&cfg_ready` registers `weight`=`cfg_weight`, sets only `weight_valid[index]` for one cycle, then increments the index. Weights arrive in index order: slice-major, MAC-minor. Acceptance of index `SLICE_NB*MAC_NB-1` → `RUN`. `load_start` is ignored.
- `RUN`: `loaded`=1 and `image_in_ready`=1. Each accepted beat registers to `image_out` with `image_out_valid`=1. Without an accepted beat, `image_out_valid`=0 and `image_out` holds. `load_start` → `DRAIN` at the next edge. A beat accepted in the same cycle as `load_start` is forwarded normally.
- `DRAIN`: `loaded`=0, `image_in_ready`=0, `cfg_ready`=0. The counter loads `DRAIN_CYCLES` on entry and decrements each cycle. At 0 → `LOAD` with index 0. `load_start` is ignored.
- Index counter width is `$clog2(SLICE_NB*MAC_NB)`, minimum 1. It never wraps inside `LOAD`.
- `rst` asserted mid-`LOAD` or mid-`RUN` returns to `EMPTY` at the next edge. The kernel is then non-resident and requires a full reload.

## Timing
- `cfg_ready`, `image_in_ready` and `loaded` decode from the state register only. There is no combinational path from any input to any output.
- A weight handshake at edge N produces `weight`/`weight_valid` in cycle N+1. Throughput is one weight per cycle; a full 3x3 kernel loads in 9 cycles with no bubbles.
- The last weight handshake at edge N gives `image_in_ready`=1 in cycle N+1. The first image beat therefore lands in the array after its weight latch.
- Image latency is 1 cycle. Throughput is one beat per cycle in `RUN`.
- After `load_start` at edge N: `image_in_ready`=0 from cycle N+1, and `cfg_ready`=1 from cycle N+1+DRAIN_CYCLES.

## Structure
- Shared package `conv_pkg`: state enum `kl_state_t`, `SLICE_PIPELINE`=6, and `DRAIN_CYCLES` default derived as `SLICE_PIPELINE*3+1`.
- Single module, no sub-module. The one-hot strobe is a shift of 1 by the index.

## Test plan
- Reset then `load_start` then 9 weights 1..9 back-to-back → `weight_valid` walks 0x001..0x100 with `weight`=1..9; `loaded`=1 in the cycle after the ninth handshake.
- `cfg_valid` toggled 1,0,1,… during `LOAD` → strobes occur only on handshake cycles; 18 cycles total; order preserved.
- In `RUN`, beats 0x000100020003 and 0x000400050006 on consecutive cycles → same values on `image_out` one cycle later with `image_out_valid`=1.
- `load_start` with a concurrent beat in `RUN` → beat forwarded; `image_in_ready`=0 next cycle; `cfg_ready` rises exactly 20 cycles after `load_start`.
- `load_start` pulsed during `LOAD` and `DRAIN`, and `image_in_valid` held high in `EMPTY`/`LOAD` → no state change and no `image_out_valid`.
- `rst` after weight 5 → all outputs at reset values next cycle; a new `load_start` restarts at index 0 (`weight_valid`=0x001).

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution array control path
package conv_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      LOAD,
      RUN,
      DRAIN
   } kl_state_t;

   localparam int SLICE_PIPELINE       = 6;
   localparam int DRAIN_CYCLES_DEFAULT = SLICE_PIPELINE * 3 + 1;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/kernel_loader.sv
// rtl/kernel_loader.sv - kernel weight loader and image stream gate for the convolution array
module kernel_loader
   import conv_pkg::*;
#(
   parameter int SLICE_NB     = 3,
   parameter int MAC_NB       = 3,
   parameter int WEIGHT_WIDTH = 16,
   parameter int IMAGE_WIDTH  = 16,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            load_start,
   input  logic [WEIGHT_WIDTH-1:0]         cfg_weight,
   input  logic                            cfg_valid,
   output logic                            cfg_ready,
   output logic [WEIGHT_WIDTH-1:0]         weight,
   output logic [SLICE_NB*MAC_NB-1:0]      weight_valid,
   input  logic [IMAGE_WIDTH*MAC_NB-1:0]   image_in,
   input  logic                            image_in_valid,
   output logic                            image_in_ready,
   output logic [IMAGE_WIDTH*MAC_NB-1:0]   image_out,
   output logic                            image_out_valid,
   output logic                            loaded
);

   localparam int KNB   = SLICE_NB * MAC_NB;
   localparam int IMG_W = IMAGE_WIDTH * MAC_NB;
   localparam int IDX_W = clog2_min1(KNB);
   localparam int CNT_W = clog2_min1(DRAIN_CYCLES + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KNB - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [KNB-1:0]   STROBE_0 = KNB'(1);

   kl_state_t               state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;
   logic [KNB-1:0]          wv_q, wv_d;
   logic [IMG_W-1:0]        img_q, img_d;
   logic                    img_v_q, img_v_d;
   logic                    cfg_hs;
   logic                    img_hs;

   // Handshake readiness comes from the state register alone, keeping inputs off output paths.
   assign cfg_ready       = (state_q == LOAD);
   assign image_in_ready  = (state_q == RUN);
   assign loaded          = (state_q == RUN);
   assign cfg_hs          = cfg_valid & cfg_ready;
   assign img_hs          = image_in_valid & image_in_ready;

   assign weight          = weight_q;
   assign weight_valid    = wv_q;
   assign image_out       = img_q;
   assign image_out_valid = img_v_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         idx_q    <= '0;
         cnt_q    <= '0;
         weight_q <= '0;
         wv_q     <= '0;
         img_q    <= '0;
         img_v_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         weight_q <= weight_d;
         wv_q     <= wv_d;
         img_q    <= img_d;
         img_v_q  <= img_v_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      weight_d = weight_q;
      wv_d     = '0;
      img_d    = img_q;
      img_v_d  = 1'b0;

      case (state_q)
         EMPTY: begin
            if (load_start) begin
               state_d = LOAD;
               idx_d   = '0;
            end
         end

         LOAD: begin
            if (cfg_hs) begin
               weight_d = cfg_weight;
               wv_d     = STROBE_0 << idx_q;
               if (idx_q == IDX_LAST) begin
                  state_d = RUN;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end
         end

         RUN: begin
            if (img_hs) begin
               img_d   = image_in;
               img_v_d = 1'b1;
            end
            if (load_start) begin
               state_d = DRAIN;
               cnt_d   = CNT_LOAD;
            end
         end

         DRAIN: begin
            // Leaving when the counter would reach zero gives exactly DRAIN_CYCLES idle cycles.
            if (cnt_q <= CNT_ONE) begin
               state_d = LOAD;
               idx_d   = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         default: begin
            state_d = EMPTY;
         end
      endcase
   end

endmodule

// File: tb/tb_kernel_loader.sv
// tb/tb_kernel_loader.sv - self-checking bench for kernel_loader
module tb_kernel_loader;

   localparam int KNB   = 9;
   localparam int DRAIN = 19;

   localparam int M_EMPTY = 0;
   localparam int M_LOAD  = 1;
   localparam int M_RUN   = 2;
   localparam int M_DRAIN = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_start = 1'b0;
   logic [15:0] cfg_weight = '0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [15:0] weight;
   logic [8:0]  weight_valid;
   logic [47:0] image_in = '0;
   logic        image_in_valid = 1'b0;
   logic        image_in_ready;
   logic [47:0] image_out;
   logic        image_out_valid;
   logic        loaded;

   int checks = 0;
   int errors = 0;

   kernel_loader dut (
      .clk             (clk),
      .rst             (rst),
      .load_start      (load_start),
      .cfg_weight      (cfg_weight),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .weight          (weight),
      .weight_valid    (weight_valid),
      .image_in        (image_in),
      .image_in_valid  (image_in_valid),
      .image_in_ready  (image_in_ready),
      .image_out       (image_out),
      .image_out_valid (image_out_valid),
      .loaded          (loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: phase, count of weights received, and the cycle at which the stream reopens.
   int          cyc = 0;
   int          mode = M_EMPTY;
   int          got = 0;
   int          reopen = 0;
   logic [15:0] e_weight = '0;
   logic [8:0]  e_wv = '0;
   logic [47:0] e_img = '0;
   logic        e_img_v = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         mode = M_EMPTY; got = 0;
         e_weight = '0; e_wv = '0; e_img = '0; e_img_v = 1'b0;
      end else begin
         e_wv = '0;
         e_img_v = 1'b0;
         case (mode)
            M_EMPTY: if (load_start) begin mode = M_LOAD; got = 0; end
            M_LOAD: if (cfg_valid) begin
               e_weight = cfg_weight;
               e_wv = 9'(1) << got;
               got++;
               if (got == KNB) mode = M_RUN;
            end
            M_RUN: begin
               if (image_in_valid) begin e_img = image_in; e_img_v = 1'b1; end
               if (load_start) begin mode = M_DRAIN; reopen = cyc + DRAIN; end
            end
            default: if (cyc == reopen) begin mode = M_LOAD; got = 0; end
         endcase
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("m_cfg_ready", cfg_ready, mode == M_LOAD);
         chk("m_image_in_ready", image_in_ready, mode == M_RUN);
         chk("m_loaded", loaded, mode == M_RUN);
         chk("m_weight", weight, e_weight);
         chk("m_weight_valid", weight_valid, e_wv);
         chk("m_image_out_valid", image_out_valid, e_img_v);
         chk("m_image_out", image_out, e_img);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   int n;
   int strobes;

   initial begin
      step();
      step();
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_weight_valid", weight_valid, 0);
      chk("rst_image_out_valid", image_out_valid, 0);
      chk("rst_loaded", loaded, 0);
      rst = 1'b0;

      // Pending cfg_valid in EMPTY is ignored; then a back-to-back 9-weight load.
      cfg_valid = 1'b1; cfg_weight = 16'hDEAD;
      step();
      cfg_valid = 1'b0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      chk("load_cfg_ready", cfg_ready, 1);
      for (int k = 0; k < KNB; k++) begin
         cfg_valid = 1'b1; cfg_weight = 16'(k + 1);
         step();
         chk("walk_strobe", weight_valid, 64'(1) << k);
         chk("walk_weight", weight, 64'(k + 1));
      end
      cfg_valid = 1'b0;
      chk("walk_loaded", loaded, 1);
      chk("walk_image_in_ready", image_in_ready, 1);

      // Two consecutive beats then an idle cycle.
      image_in_valid = 1'b1; image_in = 48'h000100020003;
      step();
      chk("img1", image_out, 48'h000100020003);
      chk("img1_v", image_out_valid, 1);
      image_in = 48'h000400050006;
      step();
      chk("img2", image_out, 48'h000400050006);
      image_in_valid = 1'b0;
      step();
      chk("img_idle_v", image_out_valid, 0);
      chk("img_hold", image_out, 48'h000400050006);

      // Reload request with a concurrent beat; drain with stray load_start and held image valid.
      image_in_valid = 1'b1; image_in = 48'h0000AAAA5555; load_start = 1'b1;
      step();
      load_start = 1'b0;
      chk("drain_fwd", image_out, 48'h0000AAAA5555);
      chk("drain_fwd_v", image_out_valid, 1);
      chk("drain_ready", image_in_ready, 0);
      n = 1;
      while (!cfg_ready && n < 100) begin
         load_start = (n == 5);
         step();
         n++;
      end
      load_start = 1'b0;
      chk("drain_len", n, 20);

      // Throttled load: handshake every other cycle, stray load_start and image valid in LOAD.
      strobes = 0;
      for (int c = 0; c < 18; c++) begin
         cfg_valid = (c % 2 == 0);
         cfg_weight = 16'(16'h0100 + c / 2);
         load_start = (c == 3);
         image_in_valid = (c < 17);
         step();
         if (weight_valid != 0) strobes++;
      end
      cfg_valid = 1'b0; load_start = 1'b0; image_in_valid = 1'b0;
      chk("toggle_strobes", strobes, 9);
      chk("toggle_loaded", loaded, 1);
      chk("toggle_last_weight", weight, 16'h0108);

      // Reset mid-load after five weights, then a fresh load restarts at index 0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cfg_valid = 1'b1; cfg_weight = 16'(16'h0200 + k);
         step();
      end
      cfg_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_weight", weight, 0);
      chk("mid_rst_strobe", weight_valid, 0);
      chk("mid_rst_cfg_ready", cfg_ready, 0);
      chk("mid_rst_image_out", image_out, 0);
      image_in_valid = 1'b1;
      step();
      image_in_valid = 1'b0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      cfg_valid = 1'b1; cfg_weight = 16'h0055;
      step();
      chk("restart_strobe", weight_valid, 9'h001);
      chk("restart_weight", weight, 16'h0055);
      for (int k = 1; k < KNB; k++) begin
         cfg_weight = 16'(16'h0055 + k);
         step();
      end
      cfg_valid = 1'b0;
      chk("restart_loaded", loaded, 1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
